// File: rtl/register_pkg.sv
// rtl/register_pkg.sv - shared constants and types for the register4 shift-register family
package register_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

    // Position in the parallel word that the cnt-th serial data bit lands on.
    function automatic int bit_slot(input int cnt, input logic dir, input int width);
        return (dir == MSB_FIRST) ? (width - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// rtl/frame_bit_counter.sv - data-bit counter with clear, qualified increment and last-bit flag
module frame_bit_counter
    import register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          enb,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          term
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (enb && inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign term = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_frame_receiver.sv
// rtl/shift_frame_receiver.sv - framed serial receiver for the register4 S_OUT stream
module shift_frame_receiver
    import register_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit PARITY_ODD = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             PAR_ERR,
    output logic             FRM_ERR,
    output logic             BUSY,
    output logic [CNT_W-1:0] WORD_CNT
);

    localparam int CW = $clog2(WIDTH + 1);

    rx_state_t        state;
    rx_state_t        state_next;
    logic [CW-1:0]    cnt;
    logic             cnt_term;
    logic [WIDTH-1:0] shreg;
    logic             dir_q;
    logic             acc;
    logic             mismatch;

    logic             start_smp;
    logic             data_smp;
    logic             par_smp;
    logic             stop_smp;

    frame_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (start_smp),
        .enb   (ENB),
        .inc   (state == DATA),
        .cnt   (cnt),
        .term  (cnt_term)
    );

    always_comb begin
        state_next = state;
        start_smp  = 1'b0;
        data_smp   = 1'b0;
        par_smp    = 1'b0;
        stop_smp   = 1'b0;
        if (ENB) begin
            case (state)
                IDLE: begin
                    if (S_IN) begin
                        start_smp  = 1'b1;
                        state_next = DATA;
                    end
                end
                DATA: begin
                    data_smp = 1'b1;
                    if (cnt_term) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    par_smp    = 1'b1;
                    state_next = STOP;
                end
                STOP: begin
                    // Always back to IDLE: a 1 here is a bad stop, never a new start.
                    stop_smp   = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            BUSY     <= 1'b0;
            shreg    <= '0;
            dir_q    <= LSB_FIRST;
            acc      <= 1'b0;
            mismatch <= 1'b0;
            Q        <= '0;
            VALID    <= 1'b0;
            PAR_ERR  <= 1'b0;
            FRM_ERR  <= 1'b0;
            WORD_CNT <= '0;
        end else begin
            state   <= state_next;
            BUSY    <= (state_next != IDLE);
            VALID   <= 1'b0;
            PAR_ERR <= 1'b0;
            FRM_ERR <= 1'b0;

            if (start_smp) begin
                dir_q <= DIR;
                acc   <= 1'b0;
            end

            if (data_smp) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (i == bit_slot(int'(cnt), dir_q, WIDTH)) begin
                        shreg[i] <= S_IN;
                    end
                end
                acc <= acc ^ S_IN;
            end

            if (par_smp) begin
                mismatch <= ((acc ^ S_IN) != PARITY_ODD);
            end

            if (stop_smp) begin
                if (S_IN) begin
                    FRM_ERR <= 1'b1;
                end else if (mismatch) begin
                    PAR_ERR <= 1'b1;
                end else begin
                    Q        <= shreg;
                    VALID    <= 1'b1;
                    WORD_CNT <= WORD_CNT + CNT_W'(1);
                end
            end
        end
    end

endmodule
